// File: rtl/msg_stream_parser.sv
`default_nettype none
// =============================================================================
// msg_stream_parser: unpacks an AXI-Stream packet of count-prefixed,
// length-prefixed messages one byte per cycle and presents each message.
// Revision: 1.0
// =============================================================================
module msg_stream_parser #(
  parameter int DATA_BYTES    = 8,
  parameter int MAX_MSG_BYTES = 32,
  parameter int MIN_MSG_BYTES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       s_tready,
  input  logic                       s_tvalid,
  input  logic                       s_tlast,
  input  logic [8*DATA_BYTES-1:0]    s_tdata,
  input  logic [DATA_BYTES-1:0]      s_tkeep,
  input  logic                       s_tuser,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic [15:0]                msg_length,
  output logic [8*MAX_MSG_BYTES-1:0] msg_data,
  output logic                       msg_error
);

  localparam int c_PTR_W = $clog2(DATA_BYTES);
  localparam int c_K_W   = $clog2(MAX_MSG_BYTES + 1);

  localparam logic [2:0] c_CNT_LO   = 3'd0;
  localparam logic [2:0] c_CNT_HI   = 3'd1;
  localparam logic [2:0] c_LEN_LO   = 3'd2;
  localparam logic [2:0] c_LEN_HI   = 3'd3;
  localparam logic [2:0] c_PAYLOAD  = 3'd4;
  localparam logic [2:0] c_EMIT     = 3'd5;
  localparam logic [2:0] c_ERR_EMIT = 3'd6;
  localparam logic [2:0] c_DRAIN    = 3'd7;

  logic [2:0]                 state_q, state_d;
  logic [8*DATA_BYTES-1:0]    data_q, data_d;
  logic [DATA_BYTES-1:0]      keep_q, keep_d;
  logic                       last_q, last_d;
  logic                       abort_q, abort_d;
  logic                       bvalid_q, bvalid_d;
  logic [c_PTR_W-1:0]         ptr_q, ptr_d;
  logic                       tdone_q, tdone_d;
  logic [7:0]                 lo_q, lo_d;
  logic [15:0]                cnt_q, cnt_d;
  logic [15:0]                len_q, len_d;
  logic [c_K_W-1:0]           k_q, k_d;
  logic [8*MAX_MSG_BYTES-1:0] payload_q, payload_d;

  logic                  w_accept;
  logic                  w_keep_ok;
  logic                  w_bad_beat;
  logic [DATA_BYTES:0]   w_keep_ext;
  logic [c_PTR_W:0]      w_ptr_nxt;
  logic                  w_at_end;
  logic                  w_close;
  logic                  w_abort;
  logic                  w_parse_state;
  logic [7:0]            w_byte;
  logic [15:0]           w_len_new;
  logic                  w_len_bad;
  logic                  w_k_last;
  logic                  w_consume;

  assign s_tready   = !bvalid_q && !rst;
  assign w_accept   = s_tvalid && s_tready;
  // Legal keep is 2^k-1 with k >= 1; anything else aborts the packet.
  assign w_keep_ok  = (s_tkeep != '0) && ((s_tkeep & (s_tkeep + 1'b1)) == '0);
  assign w_bad_beat = !w_keep_ok || (!s_tlast && !(&s_tkeep)) || (s_tlast && s_tuser);

  assign w_keep_ext = {1'b0, keep_q};
  assign w_ptr_nxt  = {1'b0, ptr_q} + 1'b1;
  assign w_at_end   = !w_keep_ext[w_ptr_nxt];
  assign w_close    = w_at_end && last_q;
  assign w_abort    = bvalid_q && abort_q;
  assign w_byte     = data_q[8*ptr_q +: 8];
  assign w_len_new  = {w_byte, lo_q};
  assign w_len_bad  = (w_len_new < 16'(MIN_MSG_BYTES)) || (w_len_new > 16'(MAX_MSG_BYTES));
  assign w_k_last   = (16'(k_q) == (len_q - 16'd1));
  assign w_parse_state = (state_q == c_CNT_LO) || (state_q == c_CNT_HI) ||
                         (state_q == c_LEN_LO) || (state_q == c_LEN_HI) ||
                         (state_q == c_PAYLOAD);

  always_ff @(posedge clk) begin
    if (rst) state_q <= c_CNT_LO;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    keep_d    = keep_q;
    last_d    = last_q;
    abort_d   = abort_q;
    bvalid_d  = bvalid_q;
    ptr_d     = ptr_q;
    tdone_d   = tdone_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    k_d       = k_q;
    payload_d = payload_q;
    w_consume = 1'b0;

    if (w_abort && w_parse_state) begin
      state_d = c_ERR_EMIT;
    end else begin
      case (state_q)
        c_CNT_LO: if (bvalid_q) begin
          w_consume = 1'b1;
          lo_d      = w_byte;
          state_d   = w_close ? c_ERR_EMIT : c_CNT_HI;
        end
        c_CNT_HI: if (bvalid_q) begin
          w_consume = 1'b1;
          cnt_d     = w_len_new;
          state_d   = ((w_len_new == 16'd0) || w_close) ? c_ERR_EMIT : c_LEN_LO;
        end
        c_LEN_LO: if (bvalid_q) begin
          w_consume = 1'b1;
          lo_d      = w_byte;
          payload_d = '0;
          state_d   = w_close ? c_ERR_EMIT : c_LEN_HI;
        end
        c_LEN_HI: if (bvalid_q) begin
          w_consume = 1'b1;
          len_d     = w_len_new;
          k_d       = '0;
          state_d   = (w_len_bad || w_close) ? c_ERR_EMIT : c_PAYLOAD;
        end
        c_PAYLOAD: if (bvalid_q) begin
          w_consume               = 1'b1;
          payload_d[8*k_q +: 8]   = w_byte;
          k_d                     = k_q + c_K_W'(1);
          if (w_k_last)     state_d = c_EMIT;
          else if (w_close) state_d = c_ERR_EMIT;
        end
        c_EMIT: if (msg_ready) begin
          cnt_d = cnt_q - 16'd1;
          // Running out of packet with messages still owed is a truncation.
          if (cnt_q != 16'd1) begin
            state_d = tdone_q ? c_ERR_EMIT : c_LEN_LO;
          end else if (tdone_q) begin
            state_d = c_CNT_LO;
            len_d   = '0;
          end else begin
            state_d = c_ERR_EMIT;
          end
        end
        c_ERR_EMIT: if (msg_ready) begin
          if (w_abort || !tdone_q) begin
            state_d = c_DRAIN;
          end else begin
            state_d = c_CNT_LO;
            len_d   = '0;
          end
        end
        c_DRAIN: if (bvalid_q) begin
          // An aborted beat may have holes in keep, so it is dropped whole.
          if (abort_q) begin
            bvalid_d = 1'b0;
            tdone_d  = last_q;
            if (last_q) begin
              state_d = c_CNT_LO;
              len_d   = '0;
            end
          end else begin
            w_consume = 1'b1;
            if (w_close) begin
              state_d = c_CNT_LO;
              len_d   = '0;
            end
          end
        end
        default: state_d = c_CNT_LO;
      endcase
    end

    if (w_consume) begin
      ptr_d   = w_ptr_nxt[c_PTR_W-1:0];
      tdone_d = w_close;
      if (w_at_end) bvalid_d = 1'b0;
    end

    if (w_accept) begin
      data_d   = s_tdata;
      keep_d   = s_tkeep;
      last_d   = s_tlast;
      abort_d  = w_bad_beat;
      bvalid_d = 1'b1;
      ptr_d    = '0;
    end
  end

  always_comb begin
    msg_valid  = 1'b0;
    msg_error  = 1'b0;
    msg_length = '0;
    msg_data   = '0;
    case (state_q)
      c_EMIT: begin
        msg_valid  = 1'b1;
        msg_length = len_q;
        msg_data   = payload_q;
      end
      c_ERR_EMIT: begin
        msg_valid  = 1'b1;
        msg_error  = 1'b1;
        msg_length = len_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      keep_q    <= '0;
      last_q    <= 1'b0;
      abort_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      ptr_q     <= '0;
      tdone_q   <= 1'b0;
      lo_q      <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      k_q       <= '0;
      payload_q <= '0;
    end else begin
      data_q    <= data_d;
      keep_q    <= keep_d;
      last_q    <= last_d;
      abort_q   <= abort_d;
      bvalid_q  <= bvalid_d;
      ptr_q     <= ptr_d;
      tdone_q   <= tdone_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      k_q       <= k_d;
      payload_q <= payload_d;
    end
  end

endmodule
`default_nettype wire
